// File: rtl/fetch_pkg.sv
// Shared types for the stage-0 fetch queue.
// State encoding, queue entry layout and default sizes.
package fetch_pkg;

  localparam int FQ_DEPTH     = 4;
  localparam int FQ_ADDR_LEN  = 12;
  localparam int FQ_INSTR_LEN = 19;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [FQ_ADDR_LEN-1:0]  pc_plus1;
    logic [FQ_INSTR_LEN-1:0] instruction;
  } fq_entry_t;

endpackage

// File: rtl/fq_fifo.sv
// Circular buffer of fetch entries with clear, push and pop.
// Clear wins over push/pop; pointers wrap modulo DEPTH.
module fq_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = FQ_DEPTH,
  parameter type entry_t = fq_entry_t
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   clear,
  input  entry_t                 din,
  output logic [$clog2(DEPTH):0] count,
  output entry_t                 head
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  entry_t          mem_q [DEPTH];
  logic [PW-1:0]   wr_q;
  logic [PW-1:0]   rd_q;
  logic [CW-1:0]   cnt_q;

  // Storage, pointers and occupancy update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (clear) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= din;
        wr_q        <= wr_q + PW'(1);
      end
      if (pop) begin
        rd_q <= rd_q + PW'(1);
      end
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
    end
  end

  assign count = cnt_q;
  assign head  = mem_q[rd_q];

endmodule

// File: rtl/fetch_queue.sv
// Stage-0 fetch: issues imem requests, queues words with PC+1.
// Optional FETCH_QUEUE_BYPASS_EN forwards an ack straight out when empty.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int ADDRESS_LEN     = FQ_ADDR_LEN,
  parameter int INSTRUCTION_LEN = FQ_INSTR_LEN,
  parameter int DEPTH           = FQ_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       redirect,
  input  logic [ADDRESS_LEN-1:0]     redirect_pc,
  output logic                       imem_req,
  output logic [ADDRESS_LEN-1:0]     imem_addr,
  input  logic                       imem_ack,
  input  logic [INSTRUCTION_LEN-1:0] imem_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [INSTRUCTION_LEN-1:0] out_instruction,
  output logic [ADDRESS_LEN-1:0]     out_pc_plus1
);

  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [ADDRESS_LEN-1:0]     pc_plus1;
    logic [INSTRUCTION_LEN-1:0] instruction;
  } fq_slot_t;

  fetch_state_t           state_q, state_d;
  logic [ADDRESS_LEN-1:0] pc_q, pc_d;
  logic [ADDRESS_LEN-1:0] addr_q, addr_d;
  logic [ADDRESS_LEN-1:0] pc_inc;
  logic [CW-1:0]          count, count_nx;
  fq_slot_t               head, din;
  logic                   fifo_valid;
  logic                   ack_live;
  logic                   push, pop;
  logic                   slot_free;

  assign pc_inc     = pc_q + ADDRESS_LEN'(1);
  assign fifo_valid = (count != '0);
  assign ack_live   = (state_q == WAIT) && imem_ack && !redirect;
  assign pop        = fifo_valid && out_ready && !redirect;
  assign din        = '{pc_plus1: pc_inc, instruction: imem_data};

`ifdef FETCH_QUEUE_BYPASS_EN
  logic byp;
  assign byp  = ack_live && !fifo_valid;
  assign push = ack_live && !(byp && out_ready);
  assign out_valid       = fifo_valid || byp;
  assign out_instruction = byp ? imem_data : head.instruction;
  assign out_pc_plus1    = byp ? pc_inc : head.pc_plus1;
`else
  assign push = ack_live;
  assign out_valid       = fifo_valid;
  assign out_instruction = head.instruction;
  assign out_pc_plus1    = head.pc_plus1;
`endif

  // Occupancy after this edge decides whether another fetch fits.
  assign count_nx  = redirect ? '0 : count + CW'(push) - CW'(pop);
  assign slot_free = (count_nx < CW'(DEPTH));

  assign imem_req  = (state_q == WAIT) || (state_q == DROP);
  assign imem_addr = addr_q;

  fq_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (fq_slot_t)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .clear (redirect),
    .din   (din),
    .count (count),
    .head  (head)
  );

  // Request FSM: address only moves when a new request starts.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    unique case (state_q)
      IDLE: begin
        if (redirect) pc_d = redirect_pc;
        if (slot_free) begin
          state_d = WAIT;
          addr_d  = pc_d;
        end
      end
      WAIT: begin
        if (redirect) begin
          pc_d    = redirect_pc;
          state_d = imem_ack ? IDLE : DROP;
        end else if (imem_ack) begin
          pc_d = pc_inc;
          if (slot_free) addr_d  = pc_inc;
          else           state_d = IDLE;
        end
      end
      DROP: begin
        if (redirect) pc_d = redirect_pc;
        if (imem_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, fetch PC and held request address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
    end
  end

endmodule
